// File: rtl/bcd_convert_arbiter.sv
// Purpose : shared binary-to-BCD converter for the 8-digit display path; round-robin
//           arbitration between two requesters, then one double-dabble bit per cycle.
// Latency : ack one cycle after capture; done 27 cycles after capture; 29 cycles per conversion.
// Backpressure: req is level-held until ack; requests arriving while busy wait for IDLE.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req[1:0]            per-requester conversion request (0 = calculator, 1 = entry)
//   i_bin_a, i_bin_b      binary operands for requester 0 / 1
//   o_ack[1:0]            one-cycle capture acknowledge, one-hot or zero
//   o_busy                conversion in progress (SHIFT or DONE)
//   o_done                one-cycle result strobe
//   o_done_id             requester that owns o_bcd_out
//   o_bcd_out             packed BCD result, digit 7 in the top nibble
//   o_overflow            last result was saturated to all nines
module bcd_convert_arbiter #(
    parameter int WIDTH   = 27,
    parameter int DIGITS  = 8,
    parameter int MAX_VAL = 99_999_999
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req,
    input  logic [WIDTH-1:0]      i_bin_a,
    input  logic [WIDTH-1:0]      i_bin_b,
    output logic [1:0]            o_ack,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_done_id,
    output logic [4*DIGITS-1:0]   o_bcd_out,
    output logic                  o_overflow
);

    localparam int                  CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]       LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]    SAT_LIMIT = WIDTH'(MAX_VAL);
    localparam logic [4*DIGITS-1:0] SAT_BCD   = {DIGITS{4'h9}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_sr;
    logic [4*DIGITS-1:0] r_acc;
    logic                r_id;
    logic                r_ovf;
    logic                r_last;
    logic [1:0]          r_ack;
    logic                r_done;
    logic                r_done_id;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_ovf_out;

    logic                w_win;
    logic [WIDTH-1:0]    w_op;
    logic [4*DIGITS-1:0] w_adj;
    logic [4*DIGITS-1:0] w_acc_next;

    // Round-robin: a tie goes to whoever was not granted last.
    always_comb begin
        w_win = 1'b0;
        case (i_req)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    assign w_op = w_win ? i_bin_b : i_bin_a;

    // Double-dabble step: add 3 to every digit >= 5 (wrapping inside the nibble),
    // then shift the operand MSB into the accumulator LSB.
    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
        w_acc_next = (w_adj << 1) | (4*DIGITS)'(r_sr[WIDTH-1]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sr      <= '0;
            r_acc     <= '0;
            r_id      <= 1'b0;
            r_ovf     <= 1'b0;
            r_last    <= 1'b1;
            r_ack     <= 2'b00;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_bcd     <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            r_ack  <= 2'b00;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_sr    <= w_op;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_ovf   <= (w_op > SAT_LIMIT);
                        r_ack   <= w_win ? 2'b10 : 2'b01;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt + CW'(1);
                    // The last iteration's result goes straight to the output register,
                    // so the display never sees a partial accumulator.
                    if (r_cnt == LAST_ITER) begin
                        r_bcd     <= r_ovf ? SAT_BCD : w_acc_next;
                        r_done_id <= r_id;
                        r_ovf_out <= r_ovf;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack      = r_ack;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_done_id  = r_done_id;
    assign o_bcd_out  = r_bcd;
    assign o_overflow = r_ovf_out;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Purpose : directed and randomised checks of bcd_convert_arbiter against a decimal reference.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_bcd_convert_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [26:0] bin_a;
    logic [26:0] bin_b;
    logic [1:0]  ack;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [31:0] bcd_out;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    bcd_convert_arbiter dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_bin_a    (bin_a),
        .i_bin_b    (bin_b),
        .o_ack      (ack),
        .o_busy     (busy),
        .o_done     (done),
        .o_done_id  (done_id),
        .o_bcd_out  (bcd_out),
        .o_overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: digit-by-digit division, saturating above the display range.
    function automatic logic [31:0] ref_bcd(input longint v);
        logic [31:0] r;
        longint      x;
        r = '0;
        x = v;
        if (x > 64'd99_999_999) return 32'h9999_9999;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated conversion on requester id, checked end to end.
    task automatic do_conv(input int id, input logic [26:0] val);
        int k;
        if (id == 0) begin bin_a = val; req = 2'b01; end
        else         begin bin_b = val; req = 2'b10; end
        k = 0;
        do begin tick(); k++; end while (ack == 2'b00 && k < 40);
        chk("ack", 32'(ack), (id == 0) ? 32'd1 : 32'd2);
        chk("ack_lat", k, 1);
        req = 2'b00;
        k = 0;
        do begin tick(); k++; end while (!done && k < 40);
        chk("done_lat", k, 27);
        chk("bcd", bcd_out, ref_bcd(longint'(val)));
        chk("done_id", 32'(done_id), 32'(id));
        chk("ovf", 32'(overflow), (val > 27'd99_999_999) ? 32'd1 : 32'd0);
        tick();
        chk("idle_after", {30'd0, busy, done}, 32'd0);
    endtask

    // Concurrent watchdogs: ack never two-hot; bcd_out only moves with done.
    logic [31:0] prev_bcd = '0;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            tests++;
            assert (ack !== 2'b11) else begin
                fails++;
                $error("FAIL ack_onehot: observed %b expected not 11", ack);
            end
            if (!done) begin
                tests++;
                assert (bcd_out === prev_bcd) else begin
                    fails++;
                    $error("FAIL bcd_hold: observed %h expected %h", bcd_out, prev_bcd);
                end
            end
        end
        prev_bcd = bcd_out;
    end

    initial begin
        int k, n, lastk, a1, d0k, d1k;
        logic [31:0] d0b, d1b;
        logic        d1id;
        logic [26:0] v;

        rst_n = 1'b0;
        req   = 2'b00;
        bin_a = '0;
        bin_b = '0;
        repeat (3) tick();
        chk("rst_ack",  32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  bcd_out, 32'd0);
        chk("rst_id_ovf", {30'd0, done_id, overflow}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single conversion and range boundaries.
        do_conv(0, 27'd12_345_678);
        do_conv(1, 27'd0);
        do_conv(1, 27'd99_999_999);
        do_conv(1, 27'd100_000_000);
        do_conv(1, 27'h7FF_FFFF);

        // Both requesting continuously: alternate, 29 cycles apart (last grant was 1).
        req = 2'b11; bin_a = 27'd5; bin_b = 27'd10;
        n = 0; k = 0; lastk = 0;
        while (n < 4 && k < 200) begin
            tick(); k++;
            if (done) begin
                chk("tie_id", 32'(done_id), 32'(n % 2));
                chk("tie_bcd", bcd_out, (n % 2 == 1) ? 32'h10 : 32'h5);
                if (n > 0) chk("tie_gap", k - lastk, 29);
                lastk = k;
                n++;
            end
        end
        req = 2'b00;
        chk("tie_count", n, 4);
        repeat (2) tick();

        // Request from 1 arriving mid-conversion of 0.
        bin_a = 27'd7; req = 2'b01;
        tick();
        chk("busy_ack0", 32'(ack), 32'd1);
        req = 2'b00;
        k = 0; a1 = -1; d0k = -1; d1k = -1; d0b = '0; d1b = '0; d1id = 1'b0;
        while (k < 60) begin
            tick(); k++;
            if (k == 10) begin bin_b = 27'd123; req = 2'b10; end
            if (ack[1] && a1 < 0) begin a1 = k; req = 2'b00; end
            if (done && d0k < 0) begin d0k = k; d0b = bcd_out; end
            else if (done) begin d1k = k; d1b = bcd_out; d1id = done_id; end
        end
        chk("busy_ack1_at", a1, 29);
        chk("busy_done0_at", d0k, 27);
        chk("busy_bcd0", d0b, 32'h7);
        chk("busy_done1_at", d1k, 56);
        chk("busy_bcd1", d1b, 32'h123);
        chk("busy_id1", 32'(d1id), 32'd1);

        // Reset in the middle of a conversion.
        bin_a = 27'd999; req = 2'b01;
        tick();
        req = 2'b00;
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd", bcd_out, 32'd0);
        chk("mid_rst_id", 32'(done_id), 32'd0);
        chk("mid_rst_ack_done_ovf", {29'd0, ack, done} | {31'd0, overflow}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        repeat (35) begin tick(); if (done) n++; end
        chk("mid_rst_no_done", n, 0);

        // First tie after reset goes to requester 0.
        bin_a = 27'd42; bin_b = 27'd77; req = 2'b11;
        tick();
        chk("post_rst_tie", 32'(ack), 32'd1);
        req = 2'b00;
        k = 0;
        do begin tick(); k++; end while (!done && k < 40);
        chk("post_rst_bcd", bcd_out, 32'h42);
        chk("post_rst_id", 32'(done_id), 32'd0);
        tick();

        // Randomised operands and requesters, with extra weight near the saturation limit.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0)
                v = 27'(99_999_990 + $urandom_range(0, 20));
            else
                v = 27'($urandom_range(0, 27'h7FF_FFFF));
            do_conv(int'($urandom_range(0, 1)), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
